sr_ram_arbiter: RTL and testbench
=================================

SR_RAM_ARBITER -- requirements
Module: sr_ram_arbiter

Interface
REQ-001 SHALL have parameter N_CORES, default 4, meaning the number of sr_cpu memory ports arbitrated (2..16).
REQ-002 SHALL have parameter RAM_AW, default 10, meaning the RAM word-address width.
REQ-003 SHALL have parameter CMD_LOAD, default 3'b001, meaning the core load command code.
REQ-004 SHALL have parameter CMD_STORE, default 3'b010, meaning the core store command code; any other code means idle.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port core_cmd, input, 3*N_CORES bits: per-core aguInstructionOut, with core i at [3i+2:3i].
REQ-008 SHALL have port core_addr, input, 32*N_CORES bits: per-core byte address (ramAddress).
REQ-009 SHALL have port core_wdata, input, 32*N_CORES bits: per-core store data (dataFromCpu).
REQ-010 SHALL have port core_rdata, output, 32*N_CORES bits: per-core load data (dataToCpu).
REQ-011 SHALL have port core_data_received, output, N_CORES bits: per-core load-complete pulse.
REQ-012 SHALL have port core_instr_taken, output, N_CORES bits: per-core store-accepted pulse.
REQ-013 SHALL have port ram_addr, output, RAM_AW bits: word address to the single-port synchronous RAM.
REQ-014 SHALL have port ram_wdata, output, 32 bits: RAM write data.
REQ-015 SHALL have ports ram_we and ram_re, output, 1 bit each: RAM write strobe and read strobe.
REQ-016 SHALL have port ram_rdata, input, 32 bits: RAM read data, valid exactly one cycle after ram_re.
REQ-017 SHALL have port busy, output, 1 bit, and port grant_id, output, 4 bits: debug signals giving the FSM not-IDLE flag and the current owner.

Function
REQ-018 SHALL implement an FSM with three states: IDLE, ACCESS and RESP.
REQ-019 In IDLE, when any core_cmd is LOAD or STORE, the FSM SHALL register the round-robin winner into grant_id and go to ACCESS; with no request it SHALL stay in IDLE.
REQ-020 Round-robin SHALL search from pointer rr_ptr upward with wrap-around; on each grant, rr_ptr SHALL become (winner+1) mod N_CORES.
REQ-021 In ACCESS, ram_addr SHALL equal core_addr[g][RAM_AW+1:2], where g = grant_id; upper address bits SHALL be ignored.
REQ-022 For a STORE in ACCESS, the block SHALL assert ram_we=1, set ram_wdata=core_wdata[g], pulse core_instr_taken[g] for that cycle only, and go to IDLE.
REQ-023 For a LOAD in ACCESS, the block SHALL assert ram_re=1 and go to RESP.
REQ-024 In RESP, the block SHALL drive core_rdata[g]=ram_rdata, pulse core_data_received[g] for one cycle, and go to IDLE.
REQ-025 If core_cmd[g] is idle when the FSM reaches ACCESS, the block SHALL issue no RAM strobe and no pulse, and SHALL return to IDLE.
REQ-026 Latency SHALL be fixed: a STORE first seen in cycle t pulses at t+1; a LOAD first seen in cycle t pulses at t+2. The block SHALL sustain one access per 2 cycles for stores and per 3 cycles for loads.
REQ-027 The cycle after a pulse SHALL be IDLE, so a core's next command, even if identical, is treated as a new request; no access SHALL ever be performed twice.
REQ-028 At most one of ram_we and ram_re SHALL be asserted in any cycle, and at most one bit across core_data_received and core_instr_taken SHALL be set in any cycle.
REQ-029 All non-granted cores SHALL see core_rdata=0, core_data_received=0 and core_instr_taken=0; cores that are not granted remain stalled by their own logic.
REQ-030 When requests arrive simultaneously, REQ-020 SHALL decide the winner; a continuously requesting core SHALL be granted within N_CORES grants.
REQ-031 Outside ACCESS, ram_we and ram_re SHALL be 0 and ram_addr and ram_wdata SHALL be 0.
REQ-032 busy SHALL be 1 in ACCESS and RESP and 0 in IDLE.

Reset
REQ-033 With rst=1 at a clock edge, the FSM SHALL go to IDLE, rr_ptr=0 and grant_id=0, and all outputs SHALL be 0 from that edge.
REQ-034 A reset arriving in ACCESS or RESP SHALL abandon the transaction without any pulse; a RAM write whose strobe was in the same cycle as the reset edge is allowed to complete.

Verification
REQ-035 Single store: core1 sends STORE, address 0x10, data 0xDEADBEEF at t0 -> ram_we with ram_addr=4 at t1, core_instr_taken=0b0010 at t1 only.
REQ-036 Single load: RAM word 4 = 0xCAFEF00D and core2 sends LOAD, address 0x10 at t0 -> ram_re at t1; core_data_received[2]=1 and core_rdata[2]=0xCAFEF00D at t2.
REQ-037 Simultaneous requests: all 4 cores send LOAD at t0 with rr_ptr=0 -> grants in order 0,1,2,3; pulses at t2, t5, t8, t11.
REQ-038 Back-to-back identical: core0 repeats the same STORE immediately after its pulse -> exactly two ram_we cycles, separated by 2 cycles.
REQ-039 Reset mid-load: rst=1 during RESP -> no core_data_received pulse, busy=0 and rr_ptr=0 on the next cycle.
REQ-040 Withdrawn request: core3 command goes idle after the grant -> no RAM strobe and no pulse, and the FSM is in IDLE the next cycle.

Source files
------------

// File: rtl/sr_ram_arbiter.sv
// sr_ram_arbiter: round-robin arbiter giving N sr_cpu memory ports shared
// access to one single-port synchronous RAM. One transaction at a time:
// IDLE picks a winner, ACCESS drives the RAM, RESP returns load data.
module sr_ram_arbiter #(
  parameter int         N_CORES   = 4,
  parameter int         RAM_AW    = 10,
  parameter logic [2:0] CMD_LOAD  = 3'b001,
  parameter logic [2:0] CMD_STORE = 3'b010
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3*N_CORES-1:0]   core_cmd,
  input  logic [32*N_CORES-1:0]  core_addr,
  input  logic [32*N_CORES-1:0]  core_wdata,
  output logic [32*N_CORES-1:0]  core_rdata,
  output logic [N_CORES-1:0]     core_data_received,
  output logic [N_CORES-1:0]     core_instr_taken,
  output logic [RAM_AW-1:0]      ram_addr,
  output logic [31:0]            ram_wdata,
  output logic                   ram_we,
  output logic                   ram_re,
  input  logic [31:0]            ram_rdata,
  output logic                   busy,
  output logic [3:0]             grant_id
);

  localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state;
  logic [3:0]         rr_ptr;

  logic [2:0]         cmd   [N_CORES];
  logic [31:0]        addr  [N_CORES];
  logic [31:0]        wdata [N_CORES];
  logic [31:0]        rdata [N_CORES];
  logic [N_CORES-1:0] req;
  logic [N_CORES-1:0] received;
  logic [N_CORES-1:0] taken;
  logic [N_CORES-1:0] unused_addr_bits;

  // Unpack the flat per-core buses into per-core views
  generate
    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_core
      assign cmd[gi]   = core_cmd[3*gi +: 3];
      assign addr[gi]  = core_addr[32*gi +: 32];
      assign wdata[gi] = core_wdata[32*gi +: 32];
      assign req[gi]   = (cmd[gi] == CMD_LOAD) || (cmd[gi] == CMD_STORE);
      // Byte-offset and above-RAM address bits are deliberately ignored
      assign unused_addr_bits[gi] = ^{addr[gi][31:RAM_AW+2], addr[gi][1:0]};
      assign core_rdata[32*gi +: 32] = rdata[gi];
    end
  endgenerate

  assign core_data_received = received;
  assign core_instr_taken   = taken;

  // Round-robin pick: first requester at or above rr_ptr, wrapping around
  logic [4:0] cand;
  logic [3:0] winner;
  logic       req_any;
  always_comb begin
    cand    = '0;
    winner  = '0;
    req_any = 1'b0;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      cand = 5'(rr_ptr) + 5'(k);
      if (cand >= 5'(N_CORES)) cand = cand - 5'(N_CORES);
      if (req[cand[IW-1:0]]) begin
        winner  = cand[3:0];
        req_any = 1'b1;
      end
    end
  end

  // Owner's current command decides the action in ACCESS (a withdrawn
  // command gives no strobe at all)
  logic [IW-1:0] g;
  logic [2:0]    g_cmd;
  logic          is_load;
  logic          is_store;
  assign g        = grant_id[IW-1:0];
  assign g_cmd    = cmd[g];
  assign is_load  = (state == ACCESS) && (g_cmd == CMD_LOAD);
  assign is_store = (state == ACCESS) && (g_cmd == CMD_STORE);

  // RAM strobes and per-core responses; everything is zero outside the owner
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    received  = '0;
    taken     = '0;
    for (int i = 0; i < N_CORES; i++) rdata[i] = '0;
    if (is_load || is_store) ram_addr = addr[g][RAM_AW+1:2];
    if (is_store) begin
      // The write may still land during a reset cycle, but no pulse is given
      ram_we    = 1'b1;
      ram_wdata = wdata[g];
      taken[g]  = !rst;
    end
    if (is_load) ram_re = 1'b1;
    if ((state == RESP) && !rst) begin
      received[g] = 1'b1;
      rdata[g]    = ram_rdata;
    end
  end

  // Transaction sequencer: grant, access, optional response, back to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            grant_id <= winner;
            rr_ptr   <= (winner == 4'(N_CORES - 1)) ? 4'd0 : winner + 4'd1;
            state    <= ACCESS;
          end
        end
        ACCESS:  state <= is_load ? RESP : IDLE;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sr_ram_arbiter.sv
// tb_sr_ram_arbiter: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a transaction-level model.
module tb_sr_ram_arbiter;
  localparam int         N  = 4;
  localparam int         AW = 10;
  localparam logic [2:0] LD = 3'b001;
  localparam logic [2:0] ST = 3'b010;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3*N-1:0]  core_cmd;
  logic [32*N-1:0] core_addr;
  logic [32*N-1:0] core_wdata;
  logic [32*N-1:0] core_rdata;
  logic [N-1:0]    core_data_received;
  logic [N-1:0]    core_instr_taken;
  logic [AW-1:0]   ram_addr;
  logic [31:0]     ram_wdata;
  logic [31:0]     ram_rdata;
  logic            ram_we;
  logic            ram_re;
  logic            busy;
  logic [3:0]      grant_id;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_on = 1'b0;

  logic [31:0] ram  [1<<AW];
  logic [31:0] mmem [1<<AW];

  sr_ram_arbiter #(.N_CORES(N), .RAM_AW(AW), .CMD_LOAD(LD), .CMD_STORE(ST)) dut (
    .clk(clk), .rst(rst),
    .core_cmd(core_cmd), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_data_received(core_data_received),
    .core_instr_taken(core_instr_taken),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM: read data one cycle after ram_re
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= ram[ram_addr];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int i, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
    core_cmd[3*i +: 3]    = c;
    core_addr[32*i +: 32] = a;
    core_wdata[32*i +: 32] = d;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] w;
    w = 32'($urandom_range(0, 15));
    return ($urandom & 32'hFFFF_F003) | (w << 2);
  endfunction

  // ---------------- behavioural model ----------------
  // m_phase counts where the current transaction is: 0 no owner,
  // 1 owner's access cycle, 2 load-data return cycle.
  int          m_phase = 0;
  int          m_owner = 0;
  int          m_ptr   = 0;
  logic [31:0] m_ld    = '0;

  always @(negedge clk) begin : model_chk
    logic [2:0]      c;
    logic            e_we, e_re;
    logic [AW-1:0]   e_addr;
    logic [31:0]     e_wd;
    logic [N-1:0]    e_tk, e_rx;
    logic [32*N-1:0] e_rd;
    int              j;
    if (model_on) begin
      e_we = 1'b0; e_re = 1'b0; e_addr = '0; e_wd = '0;
      e_tk = '0; e_rx = '0; e_rd = '0;
      c = core_cmd[3*m_owner +: 3];
      if (m_phase == 1) begin
        e_addr = core_addr[32*m_owner + 2 +: AW];
        if (c == ST) begin
          e_we = 1'b1;
          e_wd = core_wdata[32*m_owner +: 32];
          e_tk[m_owner] = !rst;
        end else if (c == LD) begin
          e_re = 1'b1;
        end
      end
      if (m_phase == 2 && !rst) begin
        e_rx[m_owner] = 1'b1;
        e_rd[32*m_owner +: 32] = m_ld;
      end
      chk("m_busy", busy, m_phase != 0);
      chk("m_grant", grant_id, 4'(m_owner));
      chk("m_received", core_data_received, e_rx);
      chk("m_taken", core_instr_taken, e_tk);
      chk("m_rdata", core_rdata, e_rd);
      chk("m_we", ram_we, e_we);
      chk("m_re", ram_re, e_re);
      if (m_phase != 1 || e_we || e_re) chk("m_addr", ram_addr, e_addr);
      if (m_phase != 1 || e_we) chk("m_wdata", ram_wdata, e_wd);
      chk("m_one_pulse", $countones({core_data_received, core_instr_taken}) <= 1, 1'b1);
      // advance to the next cycle
      if (e_we) mmem[e_addr] = e_wd;
      if (rst) begin
        m_phase = 0; m_ptr = 0; m_owner = 0;
      end else if (m_phase == 0) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          c = core_cmd[3*j +: 3];
          if ((c == LD || c == ST) && m_phase == 0) begin
            m_owner = j;
            m_ptr   = (j + 1) % N;
            m_phase = 1;
          end
        end
      end else if (m_phase == 1 && e_re) begin
        m_ld    = mmem[e_addr];
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end
  end

  // Let requesting cores run until each has seen its pulse, then go idle
  task automatic drain(input int budget);
    int           left;
    logic [N-1:0] rx, tk;
    left = budget;
    while (core_cmd != '0 && left > 0) begin
      @(negedge clk);
      rx = core_data_received;
      tk = core_instr_taken;
      step();
      for (int i = 0; i < N; i++) if (rx[i] || tk[i]) set_core(i, 3'b000, 32'h0, 32'h0);
      left--;
    end
    chk("drain_done", core_cmd == '0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [N-1:0] rx, tk, exp_rx;
    int           we_cnt, r;
    logic [2:0]   c;
    core_cmd = '0; core_addr = '0; core_wdata = '0; ram_rdata = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]  = $urandom;
      mmem[i] = ram[i];
    end
    ram[4]  = 32'hCAFEF00D;
    mmem[4] = 32'hCAFEF00D;

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_on = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_grant", grant_id, 4'd0);
    chk("reset_strobes", {ram_we, ram_re}, 2'b00);
    chk("reset_pulses", {core_data_received, core_instr_taken}, '0);

    // single load: core2, address 0x10 -> word 4
    step(); rst = 1'b0; set_core(2, LD, 32'h10, 32'h0);
    @(negedge clk); chk("ld_t0_re", ram_re, 1'b0);
    step(); @(negedge clk);
    chk("ld_t1_re", ram_re, 1'b1);
    chk("ld_t1_addr", ram_addr, 10'd4);
    chk("ld_t1_rx", core_data_received, 4'b0000);
    step(); @(negedge clk);
    chk("ld_t2_rx", core_data_received, 4'b0100);
    chk("ld_t2_rdata", core_rdata[95:64], 32'hCAFEF00D);
    step(); set_core(2, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    chk("ld_t3_busy", busy, 1'b0);
    chk("ld_t3_rx", core_data_received, 4'b0000);

    // single store: core1, address 0x10, data 0xDEADBEEF
    step(); set_core(1, ST, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("st_t0_we", ram_we, 1'b0);
    chk("st_t0_busy", busy, 1'b0);
    step(); @(negedge clk);
    chk("st_t1_we", ram_we, 1'b1);
    chk("st_t1_addr", ram_addr, 10'd4);
    chk("st_t1_wdata", ram_wdata, 32'hDEADBEEF);
    chk("st_t1_taken", core_instr_taken, 4'b0010);
    step(); set_core(1, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    chk("st_t2_taken", core_instr_taken, 4'b0000);
    chk("st_t2_we", ram_we, 1'b0);

    // simultaneous loads from rr_ptr=0: pulses at 2,5,8,11 for cores 0..3
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_core(i, LD, 32'h100 + 32'(4*i), 32'h0);
    for (int cyc = 0; cyc < 13; cyc++) begin
      @(negedge clk);
      rx = core_data_received;
      exp_rx = (cyc == 2) ? 4'b0001 : (cyc == 5) ? 4'b0010 :
               (cyc == 8) ? 4'b0100 : (cyc == 11) ? 4'b1000 : 4'b0000;
      chk($sformatf("rr_cycle%0d", cyc), rx, exp_rx);
      step();
      for (int i = 0; i < N; i++) if (rx[i]) set_core(i, 3'b000, 32'h0, 32'h0);
    end

    // back-to-back identical store from core0
    set_core(0, ST, 32'h20, 32'h12345678);
    we_cnt = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      chk($sformatf("b2b_we_cycle%0d", cyc), ram_we, (cyc == 1) || (cyc == 3));
      if (ram_we) we_cnt++;
      step();
      if (cyc == 3) set_core(0, 3'b000, 32'h0, 32'h0);
    end
    chk("b2b_we_count", we_cnt, 2);

    // reset during the response cycle of a load
    set_core(1, LD, 32'h30, 32'h0);
    @(negedge clk); step(); @(negedge clk);
    step(); rst = 1'b1;
    @(negedge clk); chk("rst_resp_rx", core_data_received, 4'b0000);
    step(); rst = 1'b0;
    set_core(1, LD, 32'h30, 32'h0);
    set_core(2, LD, 32'h40, 32'h0);
    @(negedge clk); chk("rst_after_busy", busy, 1'b0);
    step(); @(negedge clk); chk("rst_ptr_grant", grant_id, 4'd1);
    drain(40);

    // withdrawn request from core3
    step(); set_core(3, ST, 32'h50, 32'hAAAA5555);
    @(negedge clk);
    step(); set_core(3, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    chk("wd_grant", grant_id, 4'd3);
    chk("wd_busy", busy, 1'b1);
    chk("wd_strobes", {ram_we, ram_re}, 2'b00);
    chk("wd_taken", core_instr_taken, 4'b0000);
    step(); @(negedge clk); chk("wd_idle_next", busy, 1'b0);

    // randomized traffic: cores hold commands until their pulse
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rx = core_data_received;
      tk = core_instr_taken;
      step();
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        c = core_cmd[3*i +: 3];
        if (rx[i] || tk[i] || (c != LD && c != ST)) begin
          r = $urandom_range(0, 9);
          if (r < 4)      set_core(i, ST, rand_addr(), $urandom);
          else if (r < 8) set_core(i, LD, rand_addr(), $urandom);
          else            set_core(i, (r == 8) ? 3'b000 : 3'b111, rand_addr(), $urandom);
        end else if ($urandom_range(0, 29) == 0) begin
          set_core(i, 3'b000, 32'h0, 32'h0);
        end
      end
    end
    rst = 1'b0;
    core_cmd = '0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
